// File: rtl/i2s_tdm_transmitter.sv
// i2s_tdm_transmitter: N-channel I2S / TDM serial audio transmitter.
// Whole frames arrive over valid/ready into a one-frame holding buffer; the
// frame playing on the pins lives in a separate frame register. sclk is
// derived from mclk, and sd_tx/ws/frame_start/underrun are all registered
// in the same mclk cycle in which sclk falls.
//
// Frame position is tracked by bit index b plus a slot/offset pair that
// advances alongside it, so the serial bit is picked out of the frame
// register without any divide or modulo by SLOT_WIDTH.
module i2s_tdm_transmitter #(
  parameter int WIDTH      = 16,
  parameter int SLOT_WIDTH = 32,
  parameter int CHANNELS   = 2,
  parameter int MCLK_DIV   = 24
) (
  input  logic                        mclk,
  input  logic                        rst,
  input  logic [CHANNELS*WIDTH-1:0]   s_data,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic                        mode,
  output logic                        sclk,
  output logic                        ws,
  output logic                        sd_tx,
  output logic                        frame_start,
  output logic                        underrun
);

  localparam int FRAME_BITS = CHANNELS * SLOT_WIDTH;
  localparam int DATA_W     = CHANNELS * WIDTH;
  localparam int BW         = $clog2(FRAME_BITS);
  localparam int DW         = $clog2(MCLK_DIV);
  localparam int SW         = $clog2(CHANNELS);
  localparam int OW         = $clog2(SLOT_WIDTH);
  localparam int IW         = $clog2(DATA_W);

  localparam logic [DW-1:0] DIV_LAST  = DW'(MCLK_DIV / 2 - 1);
  localparam logic [BW-1:0] B_LAST    = BW'(FRAME_BITS - 1);
  localparam logic [BW-1:0] B_HALF    = BW'(FRAME_BITS / 2);
  localparam logic [BW-1:0] B_WS_I2S  = BW'(FRAME_BITS / 2 - 1);
  localparam logic [OW-1:0] OFF_LAST  = OW'(SLOT_WIDTH - 1);
  localparam logic [OW:0]   OFF_DATA  = (OW + 1)'(WIDTH);
  localparam logic [IW-1:0] IDX_WIDTH = IW'(WIDTH);
  localparam logic [IW-1:0] IDX_MSB   = IW'(WIDTH - 1);

  logic [DW-1:0]     div_q, div_d;
  logic              sclk_q, sclk_d;
  logic [BW-1:0]     b_q, b_d;
  logic [SW-1:0]     slot_q, slot_d;
  logic [OW-1:0]     off_q, off_d;
  logic              mode_q, mode_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              hold_full_q, hold_full_d;
  logic [DATA_W-1:0] frame_q, frame_d;
  logic              sd_q, sd_d;
  logic              ws_q, ws_d;
  logic              frame_start_q, frame_start_d;
  logic              underrun_q, underrun_d;

  logic              fall;
  logic              wrap;
  logic              accept;
  logic [IW-1:0]     bit_idx;

  // Next-state: sclk divider, bit position, holding-buffer handshake and
  // the serial outputs for the bit about to be driven.
  always_comb begin
    div_d         = div_q;
    sclk_d        = sclk_q;
    b_d           = b_q;
    slot_d        = slot_q;
    off_d         = off_q;
    mode_d        = mode_q;
    hold_d        = hold_q;
    hold_full_d   = hold_full_q;
    frame_d       = frame_q;
    sd_d          = sd_q;
    ws_d          = ws_q;
    frame_start_d = 1'b0;
    underrun_d    = 1'b0;
    bit_idx       = '0;

    fall   = sclk_q && (div_q == DIV_LAST);
    wrap   = fall && (b_q == B_LAST);
    accept = s_valid && !hold_full_q;

    if (div_q == DIV_LAST) begin
      div_d  = '0;
      sclk_d = !sclk_q;
    end else begin
      div_d = div_q + 1'b1;
    end

    // Accept only happens with the buffer empty, so it never collides with
    // the frame-start transfer; a same-cycle accept waits for the next frame.
    if (accept) begin
      hold_d      = s_data;
      hold_full_d = 1'b1;
    end

    if (fall) begin
      if (wrap) begin
        b_d           = '0;
        slot_d        = '0;
        off_d         = '0;
        mode_d        = mode;
        frame_start_d = 1'b1;
        if (hold_full_q) begin
          frame_d     = hold_q;
          hold_full_d = 1'b0;
        end else begin
          frame_d    = '0;
          underrun_d = 1'b1;
        end
      end else begin
        b_d = b_q + 1'b1;
        if (off_q == OFF_LAST) begin
          off_d  = '0;
          slot_d = slot_q + 1'b1;
        end else begin
          off_d = off_q + 1'b1;
        end
      end

      // I2S ws looks one bit ahead: high for b+1 in the upper half, mod frame.
      if (mode_d) begin
        ws_d = (b_d >= B_HALF);
      end else begin
        ws_d = (b_d >= B_WS_I2S) && (b_d != B_LAST);
      end

      if ({1'b0, off_d} < OFF_DATA) begin
        bit_idx = IW'(slot_d) * IDX_WIDTH + IDX_MSB - IW'(off_d);
        sd_d    = frame_d[bit_idx];
      end else begin
        sd_d = 1'b0;
      end
    end
  end

  // State register with synchronous active-high reset; reset drops any
  // buffered or in-flight frame.
  always_ff @(posedge mclk) begin
    if (rst) begin
      div_q         <= '0;
      sclk_q        <= 1'b0;
      b_q           <= B_LAST;
      slot_q        <= SW'(CHANNELS - 1);
      off_q         <= OFF_LAST;
      mode_q        <= 1'b0;
      hold_q        <= '0;
      hold_full_q   <= 1'b0;
      frame_q       <= '0;
      sd_q          <= 1'b0;
      ws_q          <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      div_q         <= div_d;
      sclk_q        <= sclk_d;
      b_q           <= b_d;
      slot_q        <= slot_d;
      off_q         <= off_d;
      mode_q        <= mode_d;
      hold_q        <= hold_d;
      hold_full_q   <= hold_full_d;
      frame_q       <= frame_d;
      sd_q          <= sd_d;
      ws_q          <= ws_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
    end
  end

  assign s_ready     = !hold_full_q;
  assign sclk        = sclk_q;
  assign ws          = ws_q;
  assign sd_tx       = sd_q;
  assign frame_start = frame_start_q;
  assign underrun    = underrun_q;

endmodule
